// File: rtl/slurm16_mem_arbiter.sv
// Single-port memory bus arbiter: execute-stage load/store wins over instruction fetch.
// Each access waits for mem_ready, or is aborted with a bus error when the wait limit is reached.
module slurm16_mem_arbiter #(
  parameter int BITS           = 16,
  parameter int ADDRESS_BITS   = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    fetch_req,
  input  logic [ADDRESS_BITS-1:0] fetch_addr,
  input  logic                    fetch_flush,
  output logic [BITS-1:0]         fetch_data,
  output logic                    fetch_valid,
  input  logic                    ls_load,
  input  logic                    ls_store,
  input  logic [ADDRESS_BITS-1:0] ls_addr,
  input  logic [BITS-1:0]         ls_wdata,
  output logic [BITS-1:0]         ls_rdata,
  output logic                    ls_done,
  output logic                    stall,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [BITS-1:0]         mem_wdata,
  output logic                    mem_rd,
  output logic                    mem_wr,
  input  logic [BITS-1:0]         mem_rdata,
  input  logic                    mem_ready,
  output logic                    bus_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            discard;
  logic            access;
  logic            timeout_end;
  logic            acc_end;
  logic [BITS-1:0] rd_val;

  always_comb begin
    access      = (state == FETCH) || (state == LOAD) || (state == STORE);
    // abort on the cycle the counter would reach the limit
    timeout_end = access && !mem_ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    acc_end     = access && (mem_ready || timeout_end);
    rd_val      = timeout_end ? {BITS{1'b1}} : mem_rdata;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (ls_store)       state_nxt = STORE;
        else if (ls_load)   state_nxt = LOAD;
        else if (fetch_req) state_nxt = FETCH;
      end
      FETCH, LOAD, STORE: if (acc_end) state_nxt = DONE;
      DONE:               state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  assign stall = (ls_load | ls_store) & ~ls_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      discard     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      ls_rdata    <= '0;
      ls_done     <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_valid <= 1'b0;
      ls_done     <= 1'b0;
      bus_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt != IDLE) begin
            wait_cnt  <= '0;
            mem_rd    <= (state_nxt != STORE);
            mem_wr    <= (state_nxt == STORE);
            mem_addr  <= (state_nxt == FETCH) ? fetch_addr : ls_addr;
            mem_wdata <= (state_nxt == STORE) ? ls_wdata : '0;
          end
        end
        FETCH, LOAD, STORE: begin
          if (state == FETCH && fetch_flush) discard <= 1'b1;
          if (acc_end) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            bus_error <= timeout_end;
            ls_done   <= (state != FETCH);
            if (state == FETCH) begin
              fetch_data  <= rd_val;
              // a flush in the final access cycle still suppresses the result
              fetch_valid <= ~(discard | fetch_flush);
            end
            if (state == LOAD) ls_rdata <= rd_val;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    discard <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slurm16_mem_arbiter.sv
// Directed bench for slurm16_mem_arbiter: load, store with waits, contention, flush, timeout, reset.
module tb_slurm16_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_req, fetch_flush, fetch_valid;
  logic [15:0] fetch_addr, fetch_data;
  logic        ls_load, ls_store, ls_done, stall;
  logic [15:0] ls_addr, ls_wdata, ls_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready, bus_error;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  slurm16_mem_arbiter #(.BITS(16), .ADDRESS_BITS(16), .TIMEOUT_CYCLES(15)) dut (
    .CLK(CLK), .RST(RST),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .ls_load(ls_load), .ls_store(ls_store), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST = 1'b1;
    fetch_req = 0; fetch_addr = '0; fetch_flush = 0;
    ls_load = 0; ls_store = 0; ls_addr = '0; ls_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    tick(2);
    chk("rst_rd_wr", {mem_rd, mem_wr}, 0);
    chk("rst_pulses", {ls_done, fetch_valid, bus_error, stall}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", {fetch_data, ls_rdata}, 0);
    RST = 1'b0;
    tick();

    // load, zero wait
    ls_load = 1; ls_addr = 16'h1234; #1;
    chk("ld_c0_stall", stall, 1);
    chk("ld_c0_rd", mem_rd, 0);
    tick();
    chk("ld_c1_rd", mem_rd, 1);
    chk("ld_c1_addr", mem_addr, 16'h1234);
    chk("ld_c1_wdata", mem_wdata, 0);
    chk("ld_c1_stall", stall, 1);
    mem_ready = 1; mem_rdata = 16'hBEEF;
    tick();
    chk("ld_c2_done", ls_done, 1);
    chk("ld_c2_rdata", ls_rdata, 16'hBEEF);
    chk("ld_c2_rd", mem_rd, 0);
    chk("ld_c2_stall", stall, 0);
    chk("ld_c2_berr", bus_error, 0);
    ls_load = 0; mem_ready = 0;
    tick();
    chk("ld_c3_done", ls_done, 0);

    // store, 3 wait states
    ls_store = 1; ls_addr = 16'h0040; ls_wdata = 16'h5A5A;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("st_c%0d_wr", i), {mem_wr, mem_rd}, 2'b10);
      chk($sformatf("st_c%0d_bus", i), {mem_addr, mem_wdata}, {16'h0040, 16'h5A5A});
      chk($sformatf("st_c%0d_done", i), ls_done, 0);
      if (i == 4) mem_ready = 1;
      tick();
    end
    chk("st_done", ls_done, 1);
    chk("st_wr_drop", mem_wr, 0);
    ls_store = 0; mem_ready = 0;
    tick();

    // contention: load wins, fetch follows
    fetch_req = 1; fetch_addr = 16'h0200; ls_load = 1; ls_addr = 16'h0300;
    tick();
    chk("ct_c1_addr", {mem_rd, mem_addr}, {1'b1, 16'h0300});
    mem_ready = 1; mem_rdata = 16'h1111;
    tick();
    chk("ct_c2_done", {ls_done, fetch_valid}, 2'b10);
    chk("ct_c2_rdata", ls_rdata, 16'h1111);
    ls_load = 0; mem_ready = 0;
    tick();
    chk("ct_c3_idle", mem_rd, 0);
    tick();
    chk("ct_c4_fetch", {mem_rd, mem_addr}, {1'b1, 16'h0200});
    mem_ready = 1; mem_rdata = 16'h2222;
    tick();
    chk("ct_c5_valid", {fetch_valid, ls_done}, 2'b10);
    chk("ct_c5_data", fetch_data, 16'h2222);
    fetch_req = 0; mem_ready = 0;
    tick();
    chk("ct_c6_valid", fetch_valid, 0);

    // flush during fetch wait
    fetch_req = 1; fetch_addr = 16'h0100;
    tick();
    chk("fl_c1_addr", {mem_rd, mem_addr}, {1'b1, 16'h0100});
    fetch_flush = 1;
    tick();
    fetch_flush = 0;
    chk("fl_c2_rd", mem_rd, 1);
    tick();
    fetch_req = 0; mem_ready = 1; mem_rdata = 16'h3333;
    tick();
    chk("fl_c4_novalid", {fetch_valid, mem_rd}, 2'b00);
    mem_ready = 0;
    tick();
    fetch_req = 1; fetch_addr = 16'h0102;
    tick();
    chk("fl2_addr", {mem_rd, mem_addr}, {1'b1, 16'h0102});
    mem_ready = 1; mem_rdata = 16'h4444;
    tick();
    chk("fl2_valid", fetch_valid, 1);
    chk("fl2_data", fetch_data, 16'h4444);
    fetch_req = 0; mem_ready = 0;
    tick();

    // timeout on load
    ls_load = 1; ls_addr = 16'h0500;
    tick();
    chk("to_c1_rd", mem_rd, 1);
    tick(14);
    chk("to_c15_rd", {mem_rd, ls_done}, 2'b10);
    tick();
    chk("to_c16_rd", mem_rd, 0);
    chk("to_c16_done", {ls_done, bus_error}, 2'b11);
    chk("to_c16_rdata", ls_rdata, 16'hFFFF);
    ls_load = 0;
    tick();
    chk("to_c17_berr", {bus_error, ls_done}, 2'b00);

    // reset during a store wait
    ls_store = 1; ls_addr = 16'h0600; ls_wdata = 16'h7777;
    tick();
    chk("rs_c1_wr", mem_wr, 1);
    tick();
    RST = 1;
    tick();
    chk("rs_wr_drop", {mem_wr, ls_done}, 2'b00);
    chk("rs_addr", mem_addr, 0);
    RST = 0; ls_store = 0;
    ls_load = 1; ls_addr = 16'h0700;
    tick();
    chk("rs_ld_addr", {mem_rd, mem_wr, mem_addr}, {2'b10, 16'h0700});
    mem_ready = 1; mem_rdata = 16'h0ABC;
    tick();
    chk("rs_ld_done", ls_done, 1);
    chk("rs_ld_rdata", ls_rdata, 16'h0ABC);
    ls_load = 0; mem_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
